// File: rtl/sdram_pkg.sv
// Shared command encodings, error codes and mode-register helpers
// for the SDRAM command responder.
package sdram_pkg;

  localparam logic [4:0] CMD_NOP = 5'b10111;
  localparam logic [4:0] CMD_ACT = 5'b10011;
  localparam logic [4:0] CMD_RD  = 5'b10101;
  localparam logic [4:0] CMD_WR  = 5'b10100;
  localparam logic [4:0] CMD_BST = 5'b10110;
  localparam logic [4:0] CMD_PRE = 5'b10010;
  localparam logic [4:0] CMD_REF = 5'b10001;
  localparam logic [4:0] CMD_LMR = 5'b10000;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_NO_MODE   = 3'd1,
    ERR_ACT_OPEN  = 3'd2,
    ERR_RW_CLOSED = 3'd3,
    ERR_REF_OPEN  = 3'd4,
    ERR_BAD_LMR   = 3'd5,
    ERR_TIMING    = 3'd6
  } err_e;

  localparam int MR_BL_LSB  = 0;
  localparam int MR_BT_BIT  = 3;
  localparam int MR_CL_LSB  = 4;
  localparam int MR_WBM_BIT = 9;
  localparam int A_AP_BIT   = 10;

  // 0 flags an unsupported burst-length field
  function automatic logic [3:0] bl_decode(input logic [2:0] f);
    case (f)
      3'b000:  return 4'd1;
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      3'b011:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] col_next(
    input logic [7:0] c,
    input logic [2:0] m
  );
    return (c & ~{5'b0, m}) | ((c + 8'd1) & {5'b0, m});
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency delay line (depth 3) carrying {valid, data} to the
// registered DQ output; CL selects the tap feeding the output stage.
module sdram_rd_pipe #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cl3_i,
  input  logic          v_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] dq_o,
  output logic          oe_o
);

  logic [1:0]    v_q;
  logic [DW-1:0] d_q [2];
  logic [DW-1:0] dq_q;
  logic          oe_q;
  logic          tap_v;
  logic [DW-1:0] tap_d;

  assign tap_v = cl3_i ? v_q[1] : v_q[0];
  assign tap_d = cl3_i ? d_q[1] : d_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q    <= '0;
      d_q[0] <= '0;
      d_q[1] <= '0;
      dq_q   <= '0;
      oe_q   <= 1'b0;
    end else begin
      v_q    <= {v_q[0], v_i};
      d_q[0] <= d_i;
      d_q[1] <= d_q[0];
      oe_q   <= tap_v;
      dq_q   <= tap_v ? tap_d : '0;
    end
  end

  assign dq_o = dq_q;
  assign oe_o = oe_q;

endmodule

// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM responder with burst storage and sticky error capture.
// Define SDRAM_TIMING_CHK_EN to build the tRCD/tRP/tRFC checkers.
module sdram_cmd_responder
  import sdram_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ROW_USED = 2,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2,
  parameter int T_RFC    = 7
) (
  input  logic          CLK_100M,
  input  logic          RST,
  input  logic          SDRAM_CKE,
  input  logic          SDRAM_CS,
  input  logic          SDRAM_RAS,
  input  logic          SDRAM_CAS,
  input  logic          SDRAM_WE,
  input  logic [1:0]    SDRAM_BA,
  input  logic [11:0]   SDRAM_ADDR,
  input  logic [DW-1:0] SDRAM_DQ_IN,
  output logic [DW-1:0] SDRAM_DQ_OUT,
  output logic          SDRAM_DQ_OE,
  output logic          MODE_VALID,
  output logic [3:0]    BANK_OPEN,
  output logic          ERR_FLAG,
  output logic [2:0]    ERR_CODE
);

  localparam int AW = 2 + ROW_USED + 8;

  logic [4:0] cmd;
  logic is_nop, is_act, is_rd, is_wr;
  logic is_bst, is_pre, is_ref, is_lmr;

  assign cmd    = {SDRAM_CKE, SDRAM_CS, SDRAM_RAS, SDRAM_CAS, SDRAM_WE};
  assign is_nop = cmd == CMD_NOP;
  assign is_act = cmd == CMD_ACT;
  assign is_rd  = cmd == CMD_RD;
  assign is_wr  = cmd == CMD_WR;
  assign is_bst = cmd == CMD_BST;
  assign is_pre = cmd == CMD_PRE;
  assign is_ref = cmd == CMD_REF;
  assign is_lmr = cmd == CMD_LMR;

  logic                mode_valid_q;
  logic [2:0]          mode_cl_q;
  logic [3:0]          mode_bl_q;
  logic                mode_wbm_q;
  logic [3:0]          bank_open_q, bank_open_d;
  logic [ROW_USED-1:0] row_q [4];
  logic                err_flag_q;
  err_e                err_code_q;
  logic [DW-1:0]       mem_q [1<<AW];

  logic       bst_act_q, bst_act_d;
  logic       bst_wr_q, bst_wr_d;
  logic       bst_ap_q, bst_ap_d;
  logic [1:0] bst_ba_q, bst_ba_d;
  logic [7:0] bst_col_q, bst_col_d;
  logic [2:0] bst_mask_q, bst_mask_d;
  logic [2:0] bst_left_q, bst_left_d;

  logic [2:0] lmr_cl;
  logic [3:0] lmr_bl;
  logic       lmr_bad;

  assign lmr_cl  = SDRAM_ADDR[MR_CL_LSB +: 3];
  assign lmr_bl  = bl_decode(SDRAM_ADDR[MR_BL_LSB +: 3]);
  assign lmr_bad = !(lmr_cl inside {3'd2, 3'd3}) ||
                   (lmr_bl == 4'd0) || SDRAM_ADDR[MR_BT_BIT];

  err_e fn_err, err_now;
  logic tm_err, ok;

  always_comb begin
    fn_err = ERR_NONE;
    if ((is_act || is_rd || is_wr || is_bst) && !mode_valid_q)
      fn_err = ERR_NO_MODE;
    else if (is_act && bank_open_q[SDRAM_BA])
      fn_err = ERR_ACT_OPEN;
    else if ((is_rd || is_wr) && !bank_open_q[SDRAM_BA])
      fn_err = ERR_RW_CLOSED;
    else if ((is_ref || is_lmr) && (|bank_open_q))
      fn_err = ERR_REF_OPEN;
    else if (is_lmr && lmr_bad)
      fn_err = ERR_BAD_LMR;
  end

  assign ok      = fn_err == ERR_NONE;
  assign err_now = !ok ? fn_err : (tm_err ? ERR_TIMING : ERR_NONE);

  logic do_act, do_rd, do_wr, do_bst, do_pre, do_lmr;
  assign do_act = is_act && ok;
  assign do_rd  = is_rd && ok;
  assign do_wr  = is_wr && ok;
  assign do_bst = is_bst && ok;
  assign do_pre = is_pre && ok;
  assign do_lmr = is_lmr && ok;

  logic [3:0] blen;
  logic [2:0] bmask;
  logic       stop;
  assign blen  = (is_wr && mode_wbm_q) ? 4'd1 : mode_bl_q;
  assign bmask = 3'(blen - 4'd1);
  assign stop  = do_bst || (do_pre &&
                 (SDRAM_ADDR[A_AP_BIT] || SDRAM_BA == bst_ba_q));

  logic       iss_v, iss_wr, iss_last, iss_ap;
  logic [1:0] iss_ba;
  logic [7:0] iss_col;

  // A fresh READ/WRITE always wins over the burst in flight
  always_comb begin
    bst_act_d  = bst_act_q;
    bst_wr_d   = bst_wr_q;
    bst_ap_d   = bst_ap_q;
    bst_ba_d   = bst_ba_q;
    bst_col_d  = bst_col_q;
    bst_mask_d = bst_mask_q;
    bst_left_d = bst_left_q;
    iss_v      = 1'b0;
    iss_wr     = bst_wr_q;
    iss_ba     = bst_ba_q;
    iss_col    = bst_col_q;
    iss_ap     = bst_ap_q;
    iss_last   = 1'b0;
    if (do_rd || do_wr) begin
      iss_v      = 1'b1;
      iss_wr     = do_wr;
      iss_ba     = SDRAM_BA;
      iss_col    = SDRAM_ADDR[7:0];
      iss_ap     = SDRAM_ADDR[A_AP_BIT];
      iss_last   = blen == 4'd1;
      bst_act_d  = blen != 4'd1;
      bst_wr_d   = do_wr;
      bst_ap_d   = SDRAM_ADDR[A_AP_BIT];
      bst_ba_d   = SDRAM_BA;
      bst_mask_d = bmask;
      bst_left_d = bmask;
      bst_col_d  = col_next(SDRAM_ADDR[7:0], bmask);
    end else if (bst_act_q && !stop) begin
      iss_v      = 1'b1;
      iss_last   = bst_left_q == 3'd1;
      bst_act_d  = !iss_last;
      bst_left_d = bst_left_q - 3'd1;
      bst_col_d  = col_next(bst_col_q, bst_mask_q);
    end else if (stop) begin
      bst_act_d  = 1'b0;
    end
  end

  always_comb begin
    bank_open_d = bank_open_q;
    if (iss_v && iss_last && iss_ap)
      bank_open_d[iss_ba] = 1'b0;
    if (do_pre) begin
      if (SDRAM_ADDR[A_AP_BIT]) bank_open_d = '0;
      else bank_open_d[SDRAM_BA] = 1'b0;
    end
    if (do_act)
      bank_open_d[SDRAM_BA] = 1'b1;
  end

  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      mode_valid_q <= 1'b0;
      mode_cl_q    <= 3'd3;
      mode_bl_q    <= 4'd1;
      mode_wbm_q   <= 1'b0;
      bank_open_q  <= '0;
      for (int b = 0; b < 4; b++) row_q[b] <= '0;
      err_flag_q   <= 1'b0;
      err_code_q   <= ERR_NONE;
      bst_act_q    <= 1'b0;
      bst_wr_q     <= 1'b0;
      bst_ap_q     <= 1'b0;
      bst_ba_q     <= '0;
      bst_col_q    <= '0;
      bst_mask_q   <= '0;
      bst_left_q   <= '0;
    end else begin
      if (do_lmr) begin
        mode_valid_q <= 1'b1;
        mode_cl_q    <= lmr_cl;
        mode_bl_q    <= lmr_bl;
        mode_wbm_q   <= SDRAM_ADDR[MR_WBM_BIT];
      end
      if (do_act) row_q[SDRAM_BA] <= SDRAM_ADDR[ROW_USED-1:0];
      if (!err_flag_q && err_now != ERR_NONE) begin
        err_flag_q <= 1'b1;
        err_code_q <= err_now;
      end
      bank_open_q <= bank_open_d;
      bst_act_q   <= bst_act_d;
      bst_wr_q    <= bst_wr_d;
      bst_ap_q    <= bst_ap_d;
      bst_ba_q    <= bst_ba_d;
      bst_col_q   <= bst_col_d;
      bst_mask_q  <= bst_mask_d;
      bst_left_q  <= bst_left_d;
    end
  end

  logic [AW-1:0] mem_addr;
  assign mem_addr = {iss_ba, row_q[iss_ba], iss_col};

  // Storage survives reset
  always_ff @(posedge CLK_100M) begin
    if (!RST && iss_v && iss_wr) mem_q[mem_addr] <= SDRAM_DQ_IN;
  end

  sdram_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk_i (CLK_100M),
    .rst_i (RST),
    .cl3_i (mode_cl_q == 3'd3),
    .v_i   (iss_v && !iss_wr),
    .d_i   (mem_q[mem_addr]),
    .dq_o  (SDRAM_DQ_OUT),
    .oe_o  (SDRAM_DQ_OE)
  );

`ifdef SDRAM_TIMING_CHK_EN
  logic [3:0] rcd_q [4];
  logic [3:0] rp_q [4];
  logic [3:0] rfc_q;
  logic       rp_busy;

  always_comb begin
    rp_busy = 1'b0;
    for (int b = 0; b < 4; b++) rp_busy = rp_busy || (rp_q[b] != 4'd0);
  end

  assign tm_err = ((is_rd || is_wr) && rcd_q[SDRAM_BA] != 4'd0) ||
                  (is_act && rp_q[SDRAM_BA] != 4'd0) ||
                  (is_ref && rp_busy) ||
                  (cmd[4:3] == 2'b10 && !is_nop && rfc_q != 4'd0);

  // tRP starts whenever a bank closes, explicit or auto precharge
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      for (int b = 0; b < 4; b++) begin
        rcd_q[b] <= '0;
        rp_q[b]  <= '0;
      end
      rfc_q <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (do_act && SDRAM_BA == 2'(b)) rcd_q[b] <= 4'(T_RCD - 1);
        else if (rcd_q[b] != 4'd0) rcd_q[b] <= rcd_q[b] - 4'd1;
        if (bank_open_q[b] && !bank_open_d[b]) rp_q[b] <= 4'(T_RP - 1);
        else if (rp_q[b] != 4'd0) rp_q[b] <= rp_q[b] - 4'd1;
      end
      if (is_ref && ok) rfc_q <= 4'(T_RFC - 1);
      else if (rfc_q != 4'd0) rfc_q <= rfc_q - 4'd1;
    end
  end
`else
  logic unused_tm;
  assign tm_err    = 1'b0;
  assign unused_tm = ^{T_RCD, T_RP, T_RFC, is_nop};
`endif

  logic unused_addr;
  assign unused_addr = ^{SDRAM_ADDR[11], SDRAM_ADDR[8]};

  assign MODE_VALID = mode_valid_q;
  assign BANK_OPEN  = bank_open_q;
  assign ERR_FLAG   = err_flag_q;
  assign ERR_CODE   = err_code_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Scoreboard bench for sdram_cmd_responder: read words are queued at
// issue time and compared when DQ_OE shows them.
module tb_sdram_cmd_responder;

  localparam logic [4:0] C_NOP = 5'b10111;
  localparam logic [4:0] C_ACT = 5'b10011;
  localparam logic [4:0] C_RD  = 5'b10101;
  localparam logic [4:0] C_WR  = 5'b10100;
  localparam logic [4:0] C_BST = 5'b10110;
  localparam logic [4:0] C_PRE = 5'b10010;
  localparam logic [4:0] C_REF = 5'b10001;
  localparam logic [4:0] C_LMR = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1, cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  ba = '0;
  logic [11:0] addr = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe, mode_valid, err_flag;
  logic [3:0]  bank_open;
  logic [2:0]  err_code;

  int errors = 0;
  int checks = 0;
  int oe_cnt = 0;
  logic [15:0] exp_q [$];
  logic [15:0] model [int];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  sdram_cmd_responder dut (
    .CLK_100M     (clk),
    .RST          (rst),
    .SDRAM_CKE    (cke),
    .SDRAM_CS     (cs),
    .SDRAM_RAS    (ras),
    .SDRAM_CAS    (cas),
    .SDRAM_WE     (we),
    .SDRAM_BA     (ba),
    .SDRAM_ADDR   (addr),
    .SDRAM_DQ_IN  (dq_in),
    .SDRAM_DQ_OUT (dq_out),
    .SDRAM_DQ_OE  (dq_oe),
    .MODE_VALID   (mode_valid),
    .BANK_OPEN    (bank_open),
    .ERR_FLAG     (err_flag),
    .ERR_CODE     (err_code)
  );

  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      oe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_oe: got %h, required no read word", dq_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dq_out !== mon_exp) begin
          errors++;
          $display("FAIL read_word: got %h, required %h", dq_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int key(input logic [1:0] b, input logic [11:0] r,
                             input logic [7:0] c);
    return int'({b, r[1:0], c});
  endfunction

  function automatic logic [7:0] wcol(input logic [7:0] c, input int bl,
                                      input int i);
    logic [7:0] m;
    m = 8'(bl - 1);
    return (c & ~m) | (8'(c + i) & m);
  endfunction

  task automatic issue(input logic [4:0] c, input logic [1:0] b,
                       input logic [11:0] a, input logic [15:0] d);
    {cke, cs, ras, cas, we} = c;
    ba = b;
    addr = a;
    dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(C_NOP, 2'd0, 12'd0, 16'd0);
  endtask

  task automatic hw_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_burst(input logic [1:0] b, input logic [11:0] r,
                             input logic [7:0] c, input logic [15:0] base,
                             input int bl);
    model[key(b, r, wcol(c, bl, 0))] = base;
    issue(C_WR, b, {4'b0, c}, base);
    for (int i = 1; i < bl; i++) begin
      model[key(b, r, wcol(c, bl, i))] = base + 16'(i);
      issue(C_NOP, 2'd0, 12'd0, base + 16'(i));
    end
  endtask

  task automatic read_cmd(input logic [1:0] b, input logic [11:0] r,
                          input logic [7:0] c, input logic ap,
                          input int bl, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(model[key(b, r, wcol(c, bl, i))]);
    issue(C_RD, b, {1'b0, ap, 2'b00, c}, 16'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b, required 0", dq_oe); end
    checks++; if (dq_out !== 16'h0) begin errors++; $display("FAIL rst_dq: got %h, required 0000", dq_out); end
    checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL rst_mode: got %b, required 0", mode_valid); end
    checks++; if (bank_open !== 4'h0) begin errors++; $display("FAIL rst_bank: got %h, required 0", bank_open); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL rst_errflag: got %b, required 0", err_flag); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_errcode: got %0d, required 0", err_code); end
    rst = 1'b0;
  endtask

  task automatic test_errors;
    hw_reset();
    issue(C_ACT, 2'd1, 12'd5, 16'd0);
    checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL err_nomode: got %0d, required 1", err_code); end
    checks++; if (bank_open !== 4'h0) begin errors++; $display("FAIL err_nomode_bank: got %h, required 0", bank_open); end
    hw_reset();
    issue(C_LMR, 2'd0, 12'h033, 16'd0);
    issue(C_ACT, 2'd0, 12'd1, 16'd0);
    idle(1);
    issue(C_ACT, 2'd0, 12'd2, 16'd0);
    checks++; if ({err_flag, err_code} !== {1'b1, 3'd2}) begin errors++; $display("FAIL err_act_open: got %b/%0d, required 1/2", err_flag, err_code); end
    hw_reset();
    issue(C_LMR, 2'd0, 12'h033, 16'd0);
    issue(C_ACT, 2'd0, 12'd1, 16'd0);
    idle(1);
    issue(C_REF, 2'd0, 12'd0, 16'd0);
    checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL err_ref_open: got %0d, required 4", err_code); end
    hw_reset();
    issue(C_LMR, 2'd0, 12'h043, 16'd0);
    checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL err_bad_lmr: got %0d, required 5", err_code); end
    checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL err_bad_lmr_mode: got %b, required 0", mode_valid); end
  endtask

  task automatic test_lmr;
    hw_reset();
    issue(C_LMR, 2'd0, 12'h033, 16'd0);
    checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL lmr_mode: got %b, required 1", mode_valid); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL lmr_err: got %b, required 0", err_flag); end
  endtask

  task automatic test_write_read;
    issue(C_ACT, 2'd1, 12'd5, 16'd0);
    idle(1);
    checks++; if (bank_open !== 4'b0010) begin errors++; $display("FAIL wr_bank_open: got %b, required 0010", bank_open); end
    write_burst(2'd1, 12'd5, 8'h04, 16'hA000, 8);
    read_cmd(2'd1, 12'd5, 8'h04, 1'b0, 8, 8);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rd_lat_k: got %b, required 0", dq_oe); end
    idle(1);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rd_lat_k1: got %b, required 0", dq_oe); end
    idle(1);
    checks++; if (dq_oe !== 1'b1) begin errors++; $display("FAIL rd_lat_k2: got %b, required 1", dq_oe); end
    idle(8);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rd_drain: got %0d left, required 0", exp_q.size()); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b/%0d, required 0", err_flag, err_code); end
  endtask

  task automatic test_wrap;
    int n0;
    n0 = oe_cnt;
    read_cmd(2'd1, 12'd5, 8'h06, 1'b0, 8, 8);
    idle(11);
    checks++; if (oe_cnt - n0 != 8) begin errors++; $display("FAIL wrap_count: got %0d, required 8", oe_cnt - n0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_autoprecharge;
    read_cmd(2'd1, 12'd5, 8'h00, 1'b1, 8, 8);
    idle(6);
    checks++; if (bank_open[1] !== 1'b1) begin errors++; $display("FAIL ap_early: got %b, required 1", bank_open[1]); end
    idle(1);
    checks++; if (bank_open[1] !== 1'b0) begin errors++; $display("FAIL ap_close: got %b, required 0", bank_open[1]); end
    idle(3);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ap_drain: got %0d left, required 0", exp_q.size()); end
    issue(C_RD, 2'd1, 12'h000, 16'd0);
    idle(4);
    checks++; if ({err_flag, err_code} !== {1'b1, 3'd3}) begin errors++; $display("FAIL ap_closed_rd: got %b/%0d, required 1/3", err_flag, err_code); end
  endtask

  task automatic test_burst_stop;
    int n0;
    hw_reset();
    issue(C_LMR, 2'd0, 12'h033, 16'd0);
    issue(C_ACT, 2'd1, 12'd5, 16'd0);
    idle(1);
    n0 = oe_cnt;
    read_cmd(2'd1, 12'd5, 8'h00, 1'b0, 8, 2);
    idle(1);
    issue(C_BST, 2'd0, 12'd0, 16'd0);
    idle(6);
    checks++; if (oe_cnt - n0 != 2) begin errors++; $display("FAIL bst_count: got %0d, required 2", oe_cnt - n0); end
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL bst_oe: got %b, required 0", dq_oe); end
    issue(C_PRE, 2'd0, 12'h400, 16'd0);
    idle(2);
    checks++; if (bank_open !== 4'h0) begin errors++; $display("FAIL pre_all: got %h, required 0", bank_open); end
  endtask

  task automatic test_cl2_bl4;
    int n0;
    issue(C_LMR, 2'd0, 12'h022, 16'd0);
    issue(C_ACT, 2'd1, 12'd5, 16'd0);
    idle(1);
    n0 = oe_cnt;
    read_cmd(2'd1, 12'd5, 8'h01, 1'b0, 4, 4);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL cl2_lat_k: got %b, required 0", dq_oe); end
    idle(1);
    checks++; if (dq_oe !== 1'b1) begin errors++; $display("FAIL cl2_lat_k1: got %b, required 1", dq_oe); end
    idle(5);
    checks++; if (oe_cnt - n0 != 4) begin errors++; $display("FAIL bl4_count: got %0d, required 4", oe_cnt - n0); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL cl2_err: got %b/%0d, required 0", err_flag, err_code); end
  endtask

  task automatic test_timing_reset;
    hw_reset();
    issue(C_LMR, 2'd0, 12'h033, 16'd0);
    issue(C_ACT, 2'd3, 12'd0, 16'd0);
    write_burst(2'd3, 12'd0, 8'h00, 16'hC000, 8);
`ifdef SDRAM_TIMING_CHK_EN
    checks++; if ({err_flag, err_code} !== {1'b1, 3'd6}) begin errors++; $display("FAIL trcd: got %b/%0d, required 1/6", err_flag, err_code); end
`else
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL no_timing_err: got %b/%0d, required 0", err_flag, err_code); end
`endif
    idle(1);
    read_cmd(2'd3, 12'd0, 8'h00, 1'b0, 8, 1);
    idle(2);
    rst = 1'b1;
    idle(1);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b, required 0", dq_oe); end
    rst = 1'b0;
    idle(4);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_word0: got %0d left, required 0", exp_q.size()); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b, required 0", err_flag); end
  endtask

  initial begin
    test_reset();
    test_errors();
    test_lmr();
    test_write_read();
    test_wrap();
    test_autoprecharge();
    test_burst_stop();
    test_cl2_bl4();
    test_timing_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
